wb_port_arbiter: RTL and testbench
==================================

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter DEPTH, default 2: mul/div result pending-buffer entries (power of two, >=2).
REQ-002 Parameter STARVE_LIMIT, default 4: consecutive undrained cycles before a forced pipeline stall (1..15).
REQ-003 Port clk  in  1: single clock; all state updates on rising edge.
REQ-004 Port rst_n  in  1: reset, synchronous and active-low.
REQ-005 Ports wb_valid in 1, wb_reg in 5, wb_data in 32: pipeline WB-stage write (wb_reg already resolved rt/rd/$31).
REQ-006 Ports md_valid in 1, md_reg in 5, md_data in 32, md_ready out 1: multi-cycle mul/div result; transfer when md_valid&&md_ready.
REQ-007 Ports rf_we out 1, rf_waddr out 5, rf_wdata out 32: register-file write port, combinational, written by RF on the edge.
REQ-008 Port wb_stall out 1: registered; freezes pipeline so a pending result can drain.
REQ-009 Ports q_reg in 5, q_pend out 1: hazard query; q_pend=1 when q_reg!=0 and any buffered entry targets q_reg.

Function
REQ-010 Priority: wb_stall=0 and wb_valid=1 -> grant WB; else buffer non-empty -> grant buffer head (pop on edge); else optional bypass (REQ-022); else rf_we=0.
REQ-011 wb_stall=1 -> grant buffer head regardless of wb_valid (pipeline re-presents the frozen WB write next cycle).
REQ-012 Writes with target reg 0 are discarded: never drive rf_we, never enqueued, but md handshake still completes.
REQ-013 md_ready = !full; accepted md results are enqueued at the tail on the edge, FIFO order preserved.
REQ-014 Full with simultaneous pop: md_ready stays 0 that cycle (no pass-through on full).
REQ-015 Enqueue and pop in the same cycle: count unchanged, pointers both advance modulo DEPTH.
REQ-016 Starve counter: increments each cycle buffer non-empty and head not granted; clears when head granted or buffer empty.
REQ-017 Counter reaching STARVE_LIMIT -> wb_stall=1 next cycle, held exactly one cycle, counter clears.
REQ-018 wb_stall never asserts with buffer empty; stall cycle always pops exactly one entry.
REQ-019 q_pend is combinational over valid entries only; stale slots never match.

Reset
REQ-020 rst_n=0 on an edge: buffer emptied (contents discarded, including mid-drain), pointers 0, counter 0, wb_stall=0.
REQ-021 During reset: rf_we=0, md_ready=0, q_pend=0.

Configuration
REQ-022 Macro WBARB_BYPASS_EN defined: buffer empty, wb_valid=0, wb_stall=0, md_valid=1 -> md result written directly to rf the same cycle, not enqueued; md_ready=1.
REQ-023 Macro undefined: every md result is enqueued; minimum md-to-rf latency one cycle.

Structure
REQ-024 Shared package holds REG_W=5, DATA_W=32, REG_ZERO=5'd0 and the write-request struct {reg, data}.
REQ-025 One sub-module: wbarb_fifo (DEPTH-entry circular buffer with per-entry compare for q_reg); arbitration and starve logic in top.

Verification
REQ-026 Reset, then idle -> rf_we=0, md_ready=1, wb_stall=0, q_pend=0.
REQ-027 wb_valid=1 wb_reg=8 wb_data=0x11 with md_valid=1 md_reg=9 md_data=0x22 same cycle -> rf writes r8=0x11 that cycle; r9=0x22 next idle cycle; q_pend(q_reg=9)=1 in between.
REQ-028 wb_valid held 1 continuously, one md result enqueued -> after 4 undrained cycles wb_stall=1 one cycle, rf writes md entry, counter clears.
REQ-029 Three md results back-to-back with WB busy, DEPTH=2 -> md_ready=0 on third; accepted two drain in order.
REQ-030 md_reg=0 or wb_reg=0 -> rf_we stays 0, buffer count unchanged.
REQ-031 With WBARB_BYPASS_EN, idle WB, md_reg=3 md_data=0x5 -> rf_we=1 r3=0x5 same cycle; without macro -> write one cycle later; reset mid-buffer -> entry never written.

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package wb_port_arbiter_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  // One pending register-file write: destination register and value.
  typedef struct packed {
    logic [REG_W-1:0]  wreg;
    logic [DATA_W-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/wb_port_arbiter_fifo.sv
// wbarb_fifo: DEPTH-entry circular buffer of pending mul/div results.
// A per-entry valid bit lets the hazard query ignore stale slots.
module wbarb_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [REG_W-1:0]  push_reg,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [REG_W-1:0]  head_reg,
  output logic [DATA_W-1:0] head_data,
  output logic              empty,
  output logic              full,
  input  logic [REG_W-1:0]  q_reg,
  output logic              q_pend
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wr_req_t          mem [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      vld   <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= '{wreg: push_reg, data: push_data};
        vld[wptr] <= 1'b1;
        wptr      <= wptr + 1'b1;
      end
      if (pop) begin
        vld[rptr] <= 1'b0;
        rptr      <= rptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign empty     = (count == '0);
  assign full      = (count == (AW+1)'(DEPTH));
  assign head_reg  = mem[rptr].wreg;
  assign head_data = mem[rptr].data;

  // Hazard match over live entries only; r0 never counts as pending.
  always_comb begin
    q_pend = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && (mem[i].wreg == q_reg)) q_pend = 1'b1;
    end
    if (q_reg == REG_ZERO) q_pend = 1'b0;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between the pipeline
// WB stage and a buffered multi-cycle mul/div result stream. The pipeline
// wins by default; a starve counter forces a one-cycle stall so buffered
// results cannot wait forever.
// Optional macro WBARB_BYPASS_EN: when nothing else wants the port, an md
// result is written straight through in the same cycle instead of buffered.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  input  logic [REG_W-1:0]  wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              md_valid,
  input  logic [REG_W-1:0]  md_reg,
  input  logic [DATA_W-1:0] md_data,
  output logic              md_ready,
  output logic              rf_we,
  output logic [REG_W-1:0]  rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              wb_stall,
  input  logic [REG_W-1:0]  q_reg,
  output logic              q_pend
);

  logic              empty;
  logic              full;
  logic              push;
  logic              pop;
  logic              grant_wb;
  logic              bypass;
  logic              fifo_q_pend;
  logic [REG_W-1:0]  head_reg;
  logic [DATA_W-1:0] head_data;
  logic [3:0]        starve_cnt;

  assign md_ready = rst_n && !full;
  assign grant_wb = rst_n && !wb_stall && wb_valid;
  assign pop      = rst_n && !empty && !grant_wb;

`ifdef WBARB_BYPASS_EN
  assign bypass = rst_n && empty && !wb_valid && !wb_stall && md_valid
                  && (md_reg != REG_ZERO);
`else
  assign bypass = 1'b0;
`endif

  // r0 results complete the handshake but are dropped here.
  assign push = md_valid && md_ready && (md_reg != REG_ZERO) && !bypass;

  wbarb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_reg  (md_reg),
    .push_data (md_data),
    .pop       (pop),
    .head_reg  (head_reg),
    .head_data (head_data),
    .empty     (empty),
    .full      (full),
    .q_reg     (q_reg),
    .q_pend    (fifo_q_pend)
  );

  assign q_pend = rst_n && fifo_q_pend;

  // Write-port mux: WB stage, then buffer head, then bypass, else idle.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = REG_ZERO;
    rf_wdata = '0;
    if (grant_wb) begin
      rf_we    = (wb_reg != REG_ZERO);
      rf_waddr = wb_reg;
      rf_wdata = wb_data;
    end else if (pop) begin
      rf_we    = 1'b1;
      rf_waddr = head_reg;
      rf_wdata = head_data;
    end else if (bypass) begin
      rf_we    = 1'b1;
      rf_waddr = md_reg;
      rf_wdata = md_data;
    end
  end

  // Starve counter: a stall fires only when the buffer stays non-empty, so
  // the stall cycle always has a head entry to drain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      wb_stall   <= 1'b0;
    end else begin
      wb_stall <= 1'b0;
      if (empty || pop) begin
        starve_cnt <= '0;
      end else if (starve_cnt == 4'(STARVE_LIMIT - 1)) begin
        starve_cnt <= '0;
        wb_stall   <= 1'b1;
      end else begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter (DEPTH=2, STARVE_LIMIT=4).
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        md_valid;
  logic [4:0]  md_reg;
  logic [31:0] md_data;
  logic        md_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        wb_stall;
  logic [4:0]  q_reg;
  logic        q_pend;

  int vectors     = 0;
  int miscompares = 0;

  wb_port_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wb_valid (wb_valid),
    .wb_reg   (wb_reg),
    .wb_data  (wb_data),
    .md_valid (md_valid),
    .md_reg   (md_reg),
    .md_data  (md_data),
    .md_ready (md_ready),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .wb_stall (wb_stall),
    .q_reg    (q_reg),
    .q_pend   (q_pend)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // a further unit later, well clear of either edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    wb_valid = 1'b0; wb_reg = 5'd0; wb_data = '0;
    md_valid = 1'b0; md_reg = 5'd0; md_data = '0;
  endtask

  task automatic chk_write(input string tag, input logic [4:0] a, input logic [31:0] d);
    chk({tag, "_we"},   32'(rf_we), 32'd1);
    chk({tag, "_addr"}, 32'(rf_waddr), 32'(a));
    chk({tag, "_data"}, rf_wdata, d);
  endtask

  initial begin
    rst_n = 1'b0;
    q_reg = 5'd9;
    idle_inputs();
    tick();
    // Reset with traffic present: nothing may leak out.
    wb_valid = 1'b1; wb_reg = 5'd8; wb_data = 32'h99;
    md_valid = 1'b1; md_reg = 5'd9; md_data = 32'h98;
    settle();
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_md_ready", 32'(md_ready), 32'd0);
    chk("rst_q_pend", 32'(q_pend), 32'd0);
    tick();
    chk("rst_stall", 32'(wb_stall), 32'd0);
    rst_n = 1'b1;
    idle_inputs();
    settle();
    chk("idle_rf_we", 32'(rf_we), 32'd0);
    chk("idle_md_ready", 32'(md_ready), 32'd1);
    chk("idle_stall", 32'(wb_stall), 32'd0);
    chk("idle_q_pend", 32'(q_pend), 32'd0);

    // WB and md collide: WB first, md drains next idle cycle.
    tick();
    wb_valid = 1'b1; wb_reg = 5'd8; wb_data = 32'h11;
    md_valid = 1'b1; md_reg = 5'd9; md_data = 32'h22;
    settle();
    chk_write("coll_wb", 5'd8, 32'h11);
    chk("coll_md_ready", 32'(md_ready), 32'd1);
    tick();
    idle_inputs();
    settle();
    chk("coll_q_pend", 32'(q_pend), 32'd1);
    chk_write("coll_md", 5'd9, 32'h22);
    tick();
    chk("coll_done_we", 32'(rf_we), 32'd0);
    chk("coll_done_q_pend", 32'(q_pend), 32'd0);

    // Starvation: WB held busy, one buffered result forces a stall.
    wb_valid = 1'b1; wb_reg = 5'd4; wb_data = 32'h40;
    md_valid = 1'b1; md_reg = 5'd12; md_data = 32'h0C;
    q_reg = 5'd12;
    tick();
    md_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      settle();
      chk($sformatf("starve_c%0d_stall", i), 32'(wb_stall), 32'd0);
      chk($sformatf("starve_c%0d_addr", i), 32'(rf_waddr), 32'd4);
      chk($sformatf("starve_c%0d_q_pend", i), 32'(q_pend), 32'd1);
      tick();
    end
    settle();
    chk("starve_stall", 32'(wb_stall), 32'd1);
    chk_write("starve_drain", 5'd12, 32'h0C);
    tick();
    chk("starve_release", 32'(wb_stall), 32'd0);
    chk_write("starve_wb_again", 5'd4, 32'h40);
    chk("starve_q_pend_clr", 32'(q_pend), 32'd0);

    // Fill DEPTH=2 with WB busy; the third result is refused.
    md_valid = 1'b1; md_reg = 5'd1; md_data = 32'hA1;
    settle();
    chk("fill1_ready", 32'(md_ready), 32'd1);
    tick();
    md_reg = 5'd2; md_data = 32'hA2;
    settle();
    chk("fill2_ready", 32'(md_ready), 32'd1);
    tick();
    md_reg = 5'd3; md_data = 32'hA3;
    q_reg = 5'd3;
    settle();
    chk("fill3_ready", 32'(md_ready), 32'd0);
    chk("fill3_q_pend_r3", 32'(q_pend), 32'd0);
    q_reg = 5'd2;
    settle();
    chk("fill3_q_pend_r2", 32'(q_pend), 32'd1);
    tick();
    idle_inputs();
    settle();
    chk_write("drain_first", 5'd1, 32'hA1);
    tick();
    chk_write("drain_second", 5'd2, 32'hA2);
    tick();
    chk("drain_empty_we", 32'(rf_we), 32'd0);

    // Simultaneous enqueue and pop, across the pointer wrap.
    wb_valid = 1'b1; wb_reg = 5'd4; wb_data = 32'h44;
    md_valid = 1'b1; md_reg = 5'd10; md_data = 32'h0A;
    tick();
    wb_valid = 1'b0;
    md_reg = 5'd11; md_data = 32'h0B;
    settle();
    chk("pp_ready", 32'(md_ready), 32'd1);
    chk_write("pp_pop", 5'd10, 32'h0A);
    tick();
    md_valid = 1'b0;
    settle();
    chk_write("pp_next", 5'd11, 32'h0B);
    tick();
    chk("pp_empty_we", 32'(rf_we), 32'd0);

    // Writes to r0 are dropped on both paths.
    wb_valid = 1'b1; wb_reg = 5'd0; wb_data = 32'hFF;
    md_valid = 1'b1; md_reg = 5'd0; md_data = 32'hEE;
    q_reg = 5'd0;
    settle();
    chk("r0_wb_we", 32'(rf_we), 32'd0);
    chk("r0_md_ready", 32'(md_ready), 32'd1);
    tick();
    wb_valid = 1'b0;
    settle();
    chk("r0_md_only_we", 32'(rf_we), 32'd0);
    tick();
    md_valid = 1'b0;
    settle();
    chk("r0_no_entry_we", 32'(rf_we), 32'd0);
    chk("r0_q_pend", 32'(q_pend), 32'd0);
    chk("r0_ready", 32'(md_ready), 32'd1);

    // md result with the port idle: bypass build writes at once.
    md_valid = 1'b1; md_reg = 5'd3; md_data = 32'h5;
    settle();
`ifdef WBARB_BYPASS_EN
    chk_write("byp_same", 5'd3, 32'h5);
    chk("byp_ready", 32'(md_ready), 32'd1);
    tick();
    idle_inputs();
    settle();
    chk("byp_after_we", 32'(rf_we), 32'd0);
`else
    chk("nobyp_same_we", 32'(rf_we), 32'd0);
    tick();
    idle_inputs();
    settle();
    chk_write("nobyp_next", 5'd3, 32'h5);
`endif
    tick();
    chk("md_done_we", 32'(rf_we), 32'd0);

    // Reset while an entry is buffered: it must never reach the RF.
    wb_valid = 1'b1; wb_reg = 5'd4; wb_data = 32'h44;
    md_valid = 1'b1; md_reg = 5'd7; md_data = 32'h77;
    q_reg = 5'd7;
    tick();
    idle_inputs();
    settle();
    chk("mid_q_pend", 32'(q_pend), 32'd1);
    rst_n = 1'b0;
    settle();
    chk("mid_rst_we", 32'(rf_we), 32'd0);
    chk("mid_rst_q_pend", 32'(q_pend), 32'd0);
    tick();
    rst_n = 1'b1;
    settle();
    chk("post_rst_we", 32'(rf_we), 32'd0);
    chk("post_rst_q_pend", 32'(q_pend), 32'd0);
    chk("post_rst_ready", 32'(md_ready), 32'd1);
    tick();
    chk("post_rst_we2", 32'(rf_we), 32'd0);
    chk("post_rst_stall", 32'(wb_stall), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
